// File: rtl/te_radio_seq.sv
// Radio session sequencer: waits for PLL lock, ramps the radio up, holds it
// active until stopped, and flags settle timeouts and PLL loss as one-cycle pulses.
module te_radio_seq #(
    parameter int CNT_W = 8
) (
    input  logic             ck,
    input  logic             arst,
    input  logic             startReq,
    input  logic             stopReq,
    input  logic             rxMode,
    input  logic             pllSettled,
    input  logic             isolate,
    input  logic [CNT_W-1:0] rampCycles,
    input  logic [CNT_W-1:0] settleTimeout,
    output logic             radioEnable,
    output logic             radioRxEn,
    output logic             busy,
    output logic             timeoutErr,
    output logic             pllLostErr
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_PLL = 3'd1;
    localparam logic [2:0] S_RAMP     = 3'd2;
    localparam logic [2:0] S_ACTIVE   = 3'd3;
    localparam logic [2:0] S_STOP     = 3'd4;

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             rx_mode_reg, rx_mode_next;
    logic             timeout_err_reg, timeout_err_next;
    logic             pll_lost_reg, pll_lost_next;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] ramp_last;
    logic             timeout_hit;
    logic             radio_on;

    // Config inputs are compared live, so a mid-state change applies on the next compare.
    assign cnt_inc     = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);
    assign ramp_last   = (rampCycles == '0) ? '0 : rampCycles - CNT_W'(1);
    assign timeout_hit = (settleTimeout != '0) && (cnt_reg == settleTimeout - CNT_W'(1));

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        rx_mode_next     = rx_mode_reg;
        timeout_err_next = 1'b0;
        pll_lost_next    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (startReq) begin
                    state_next   = S_WAIT_PLL;
                    cnt_next     = '0;
                    rx_mode_next = rxMode;
                end
            end
            S_WAIT_PLL: begin
                // Lock beats a same-cycle timeout; an explicit abort beats both.
                if (stopReq) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else if (pllSettled) begin
                    state_next = S_RAMP;
                    cnt_next   = '0;
                end else if (timeout_hit) begin
                    state_next       = S_IDLE;
                    cnt_next         = '0;
                    timeout_err_next = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            S_RAMP: begin
                if (!pllSettled) begin
                    state_next    = S_IDLE;
                    cnt_next      = '0;
                    pll_lost_next = 1'b1;
                end else if (stopReq) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == ramp_last) begin
                    state_next = S_ACTIVE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            S_ACTIVE: begin
                if (!pllSettled) begin
                    state_next    = S_IDLE;
                    pll_lost_next = 1'b1;
                end else if (stopReq) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge ck) begin
        if (arst) begin
            state_reg       <= S_IDLE;
            cnt_reg         <= '0;
            rx_mode_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
            pll_lost_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            rx_mode_reg     <= rx_mode_next;
            timeout_err_reg <= timeout_err_next;
            pll_lost_reg    <= pll_lost_next;
        end
    end

    // Isolation clamps only the radio enables; session state keeps running underneath.
    assign radio_on    = (state_reg == S_RAMP) || (state_reg == S_ACTIVE) || (state_reg == S_STOP);
    assign radioEnable = radio_on && !isolate;
    assign radioRxEn   = (state_reg == S_ACTIVE) && rx_mode_reg && !isolate;
    assign busy        = (state_reg != S_IDLE);
    assign timeoutErr  = timeout_err_reg;
    assign pllLostErr  = pll_lost_reg;

endmodule

// File: tb/tb_te_radio_seq.sv
// Directed bench for te_radio_seq: a phase/elapsed-time model checked every
// cycle, plus literal expectations taken from the nominal scenarios.
module tb_te_radio_seq;

    localparam int P_IDLE   = 0;
    localparam int P_WAIT   = 1;
    localparam int P_RAMP   = 2;
    localparam int P_ACTIVE = 3;
    localparam int P_STOP   = 4;

    logic       ck = 1'b0;
    logic       arst, startReq, stopReq, rxMode, pllSettled, isolate;
    logic [7:0] rampCycles, settleTimeout;
    logic       radioEnable, radioRxEn, busy, timeoutErr, pllLostErr;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    int m_ph   = P_IDLE;
    int m_el   = 0;
    bit m_rx   = 1'b0;
    bit m_terr = 1'b0;
    bit m_perr = 1'b0;

    te_radio_seq #(.CNT_W(8)) dut (
        .ck            (ck),
        .arst          (arst),
        .startReq      (startReq),
        .stopReq       (stopReq),
        .rxMode        (rxMode),
        .pllSettled    (pllSettled),
        .isolate       (isolate),
        .rampCycles    (rampCycles),
        .settleTimeout (settleTimeout),
        .radioEnable   (radioEnable),
        .radioRxEn     (radioRxEn),
        .busy          (busy),
        .timeoutErr    (timeoutErr),
        .pllLostErr    (pllLostErr)
    );

    always #5 ck = ~ck;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #2;
    endtask

    // Session model in terms of phases and cycles spent in the current phase.
    always @(posedge ck) begin
        m_terr <= 1'b0;
        m_perr <= 1'b0;
        if (arst) begin
            m_ph <= P_IDLE;
            m_el <= 0;
            m_rx <= 1'b0;
        end else begin
            case (m_ph)
                P_IDLE: if (startReq) begin
                    m_ph <= P_WAIT;
                    m_el <= 0;
                    m_rx <= rxMode;
                end
                P_WAIT: begin
                    if (stopReq) m_ph <= P_IDLE;
                    else if (pllSettled) begin
                        m_ph <= P_RAMP;
                        m_el <= 0;
                    end else if (settleTimeout != 0 && m_el + 1 == int'(settleTimeout)) begin
                        m_ph   <= P_IDLE;
                        m_terr <= 1'b1;
                    end else m_el <= m_el + 1;
                end
                P_RAMP: begin
                    if (!pllSettled) begin
                        m_ph   <= P_IDLE;
                        m_perr <= 1'b1;
                    end else if (stopReq) m_ph <= P_IDLE;
                    else if (m_el + 1 == ((rampCycles == 0) ? 1 : int'(rampCycles))) begin
                        m_ph <= P_ACTIVE;
                        m_el <= 0;
                    end else m_el <= m_el + 1;
                end
                P_ACTIVE: begin
                    if (!pllSettled) begin
                        m_ph   <= P_IDLE;
                        m_perr <= 1'b1;
                    end else if (stopReq) m_ph <= P_STOP;
                end
                default: m_ph <= P_IDLE;
            endcase
        end
    end

    always @(negedge ck) begin
        if (cmp_en) begin
            chk("cmp_radioEnable", radioEnable,
                (m_ph == P_RAMP || m_ph == P_ACTIVE || m_ph == P_STOP) && !isolate);
            chk("cmp_radioRxEn", radioRxEn, (m_ph == P_ACTIVE) && m_rx && !isolate);
            chk("cmp_busy", busy, m_ph != P_IDLE);
            chk("cmp_timeoutErr", timeoutErr, m_terr);
            chk("cmp_pllLostErr", pllLostErr, m_perr);
        end
    end

    initial begin
        arst = 1'b1; startReq = 1'b1; stopReq = 1'b0; rxMode = 1'b1;
        pllSettled = 1'b0; isolate = 1'b0; rampCycles = 8'd3; settleTimeout = 8'd0;
        repeat (2) tick();
        chk("reset_radioEnable", radioEnable, 1'b0);
        chk("reset_radioRxEn", radioRxEn, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_timeoutErr", timeoutErr, 1'b0);
        chk("reset_pllLostErr", pllLostErr, 1'b0);
        arst = 1'b0; startReq = 1'b0;
        cmp_en = 1'b1;
        tick();

        // Nominal RX session, rampCycles=3
        for (int c = 0; c < 12; c++) begin
            startReq = (c == 0); stopReq = (c == 8);
            pllSettled = 1'b1; rxMode = 1'b1; rampCycles = 8'd3;
            #1;
            case (c)
                1: begin chk("nom_busy_c1", busy, 1'b1); chk("nom_en_c1", radioEnable, 1'b0); end
                2: chk("nom_en_c2", radioEnable, 1'b1);
                4: chk("nom_rx_c4", radioRxEn, 1'b0);
                5: chk("nom_rx_c5", radioRxEn, 1'b1);
                9: begin chk("nom_rx_c9", radioRxEn, 1'b0); chk("nom_en_c9", radioEnable, 1'b1); end
                10: begin chk("nom_en_c10", radioEnable, 1'b0); chk("nom_busy_c10", busy, 1'b0); end
                default: ;
            endcase
            tick();
        end

        // Settle timeout, settleTimeout=4
        for (int c = 0; c < 8; c++) begin
            startReq = (c == 0); stopReq = 1'b0;
            pllSettled = 1'b0; settleTimeout = 8'd4;
            #1;
            case (c)
                4: begin chk("to_busy_c4", busy, 1'b1); chk("to_err_c4", timeoutErr, 1'b0); end
                5: begin chk("to_busy_c5", busy, 1'b0); chk("to_err_c5", timeoutErr, 1'b1); end
                6: chk("to_err_c6", timeoutErr, 1'b0);
                default: ;
            endcase
            tick();
        end

        // Lock arrives on the timeout cycle, then PLL is lost together with stopReq
        for (int c = 0; c < 13; c++) begin
            startReq = (c == 0); stopReq = (c == 9);
            pllSettled = (c >= 4) && (c != 9); settleTimeout = 8'd4;
            rampCycles = 8'd3; rxMode = 1'b1;
            #1;
            case (c)
                5: begin chk("tie_en_c5", radioEnable, 1'b1); chk("tie_err_c5", timeoutErr, 1'b0); end
                8: chk("tie_rx_c8", radioRxEn, 1'b1);
                10: begin
                    chk("lost_busy_c10", busy, 1'b0);
                    chk("lost_err_c10", pllLostErr, 1'b1);
                    chk("lost_en_c10", radioEnable, 1'b0);
                end
                11: chk("lost_err_c11", pllLostErr, 1'b0);
                default: ;
            endcase
            tick();
        end
        settleTimeout = 8'd0;

        // Isolation in ACTIVE, then reset during RAMP with startReq held
        for (int c = 0; c < 16; c++) begin
            startReq = (c == 0) || (c == 10) || (c == 13); stopReq = (c == 7);
            isolate = (c == 5); arst = (c == 12) || (c == 13);
            pllSettled = 1'b1; rxMode = 1'b1; rampCycles = 8'd2;
            #1;
            case (c)
                4: begin chk("iso_en_c4", radioEnable, 1'b1); chk("iso_rx_c4", radioRxEn, 1'b1); end
                5: begin
                    chk("iso_en_c5", radioEnable, 1'b0);
                    chk("iso_rx_c5", radioRxEn, 1'b0);
                    chk("iso_busy_c5", busy, 1'b1);
                end
                6: begin chk("iso_en_c6", radioEnable, 1'b1); chk("iso_rx_c6", radioRxEn, 1'b1); end
                8: begin chk("stop_rx_c8", radioRxEn, 1'b0); chk("stop_en_c8", radioEnable, 1'b1); end
                9: chk("stop_busy_c9", busy, 1'b0);
                12: chk("rst_en_c12", radioEnable, 1'b1);
                13: begin chk("rst_en_c13", radioEnable, 1'b0); chk("rst_busy_c13", busy, 1'b0); end
                14: chk("rst_busy_c14", busy, 1'b0);
                default: ;
            endcase
            tick();
        end
        arst = 1'b0; isolate = 1'b0;

        // rampCycles=0 behaves as a single RAMP cycle
        for (int c = 0; c < 7; c++) begin
            startReq = (c == 0); stopReq = (c == 4);
            pllSettled = 1'b1; rxMode = 1'b1; rampCycles = 8'd0;
            #1;
            case (c)
                2: begin chk("r0_en_c2", radioEnable, 1'b1); chk("r0_rx_c2", radioRxEn, 1'b0); end
                3: chk("r0_rx_c3", radioRxEn, 1'b1);
                default: ;
            endcase
            tick();
        end

        // stopReq during RAMP aborts without an error pulse
        for (int c = 0; c < 7; c++) begin
            startReq = (c == 0); stopReq = (c == 4);
            pllSettled = 1'b1; rxMode = 1'b0; rampCycles = 8'd10;
            #1;
            if (c == 5) begin
                chk("abort_busy_c5", busy, 1'b0);
                chk("abort_en_c5", radioEnable, 1'b0);
                chk("abort_terr_c5", timeoutErr, 1'b0);
                chk("abort_perr_c5", pllLostErr, 1'b0);
            end
            tick();
        end

        // rampCycles lowered mid-RAMP takes effect on the next compare
        for (int c = 0; c < 9; c++) begin
            startReq = (c == 0); stopReq = (c == 6);
            pllSettled = 1'b1; rxMode = 1'b1;
            rampCycles = (c < 3) ? 8'd10 : 8'd3;
            #1;
            case (c)
                4: chk("live_rx_c4", radioRxEn, 1'b0);
                5: chk("live_rx_c5", radioRxEn, 1'b1);
                default: ;
            endcase
            tick();
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
